// File: rtl/spi_flash_reader_pkg.sv
// Shared types and constants for the SPI flash word reader.
// The helper turns the on-wire byte order into the little-endian response word.
package spi_flash_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RESP  = 3'd4,
        ST_GAP   = 3'd5
    } state_e;

    localparam logic [7:0] CMD_READ = 8'h03;

    localparam int HDR_BITS   = 32;
    localparam int DATA_BITS  = 32;
    localparam int TOTAL_BITS = 64;

    // First byte received lands in [7:0], fourth byte in [31:24].
    function automatic logic [31:0] wire_to_word(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI clock generator: CLK_DIV cycles per half-period, with strobes that
// pulse in the cycle whose closing edge changes the SPI clock.
module spi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic sck_o,
    output logic tc_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;

    // clr_i wins over a terminal count, so the caller can end a phase
    // without producing a clock edge.
    always_comb begin
        tc_o   = en_i && (cnt_q == CW'(CLK_DIV - 1));
        rise_o = tc_o && !sck_q && !clr_i;
        fall_o = tc_o && sck_q && !clr_i;
        cnt_d  = cnt_q;
        sck_d  = sck_q;
        if (clr_i) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (en_i) begin
            if (tc_o) begin
                cnt_d = '0;
                sck_d = !sck_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o = sck_q;

endmodule

// File: rtl/spi_flash_reader.sv
// Mode-0 SPI initiator that reads one 32-bit word per request using READ + 24-bit address.
// Request/response channels use valid/ready: a transfer happens on a cycle where both are high.
module spi_flash_reader
    import spi_flash_reader_pkg::*;
#(
    parameter int         CLK_DIV = 2,
    parameter int         CS_IDLE = 4,
    parameter logic [7:0] CMD     = CMD_READ
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        csb,
    output logic        spiclk,
    output logic        io0,
    input  logic        io1,
    output logic [2:0]  dbg_state
);

    localparam int GW = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

    state_e                 state_q, state_d;
    logic                   csb_q, csb_d;
    logic [HDR_BITS-1:0]    hdr_q, hdr_d;
    logic [DATA_BITS-1:0]   rx_q, rx_d;
    logic [6:0]             bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]          gap_q, gap_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [31:0]            rsp_data_q, rsp_data_d;

    logic sck_en, sck_clr, sck_tc, sck_rise, sck_fall, sck;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .clk_i  (ap_clk),
        .rst_ni (ap_rst),
        .en_i   (sck_en),
        .clr_i  (sck_clr),
        .sck_o  (sck),
        .tc_o   (sck_tc),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    always_comb begin
        state_d     = state_q;
        csb_d       = csb_q;
        hdr_d       = hdr_q;
        rx_d        = rx_q;
        bit_cnt_d   = bit_cnt_q;
        gap_d       = gap_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        sck_en      = 1'b0;
        sck_clr     = 1'b0;

        // Rise count covers all 64 bits; the last 32 rises carry flash data.
        if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 7'd1;
            if (bit_cnt_q >= 7'(HDR_BITS)) begin
                rx_d = {rx_q[DATA_BITS-2:0], io1};
            end
        end
        if (sck_fall) begin
            hdr_d = {hdr_q[HDR_BITS-2:0], 1'b0};
        end

        case (state_q)
            ST_IDLE: begin
                sck_clr = 1'b1;
                if (req_valid) begin
                    hdr_d     = {CMD, req_addr};
                    csb_d     = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                sck_en = 1'b1;
                if (sck_tc) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sck_en = 1'b1;
                if (sck_tc && !sck && (bit_cnt_q == 7'(TOTAL_BITS))) begin
                    sck_clr = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                sck_en = 1'b1;
                if (sck_tc) begin
                    sck_clr     = 1'b1;
                    csb_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = wire_to_word(rx_q);
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    gap_d       = '0;
                    state_d     = (CS_IDLE == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (int'(gap_q) >= CS_IDLE - 1) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst) begin
        if (!ap_rst) begin
            state_q     <= ST_IDLE;
            csb_q       <= 1'b1;
            hdr_q       <= '0;
            rx_q        <= '0;
            bit_cnt_q   <= '0;
            gap_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            csb_q       <= csb_d;
            hdr_q       <= hdr_d;
            rx_q        <= rx_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_q       <= gap_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign csb       = csb_q;
    assign spiclk    = sck;
    assign io0       = hdr_q[HDR_BITS-1];
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: two instances (CLK_DIV=2/CS_IDLE=4 and CLK_DIV=1/CS_IDLE=0),
// each served by a behavioural flash and checked every cycle against a timing/data model.
module tb_spi_flash_reader;

    localparam int PERIOD = 10;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [23:0] req_addr  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data  [2];
    logic        busy      [2];
    logic        csb       [2];
    logic        spiclk    [2];
    logic        io0       [2];
    logic        io1       [2];
    logic [2:0]  dbg_state [2];

    int cmp_n = 0;
    int err_n = 0;
    int cyc   = 0;

    always #(PERIOD / 2) ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    spi_flash_reader #(.CLK_DIV(2), .CS_IDLE(4), .CMD(8'h03)) dut0 (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_addr  (req_addr[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_data  (rsp_data[0]),
        .busy      (busy[0]),
        .csb       (csb[0]),
        .spiclk    (spiclk[0]),
        .io0       (io0[0]),
        .io1       (io1[0]),
        .dbg_state (dbg_state[0])
    );

    spi_flash_reader #(.CLK_DIV(1), .CS_IDLE(0), .CMD(8'h03)) dut1 (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_addr  (req_addr[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_data  (rsp_data[1]),
        .busy      (busy[1]),
        .csb       (csb[1]),
        .spiclk    (spiclk[1]),
        .io0       (io0[1]),
        .io1       (io1[1]),
        .dbg_state (dbg_state[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        cmp_n++;
        if (got !== exp) begin
            err_n++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Flash contents: a small table at the bottom of memory, a hash elsewhere.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'd0:   return 8'h78;
            24'd1:   return 8'h56;
            24'd2:   return 8'h34;
            24'd3:   return 8'h12;
            24'd4:   return 8'hAB;
            24'd5:   return 8'hCD;
            24'd6:   return 8'hEF;
            24'd7:   return 8'h01;
            default: return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        return {mem_byte(a + 24'd3), mem_byte(a + 24'd2), mem_byte(a + 24'd1), mem_byte(a)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_m
        localparam int D  = (g == 0) ? 2 : 1;
        localparam int CI = (g == 0) ? 4 : 0;

        // Behavioural flash: takes cmd+addr on spiclk rises, serves data after falls.
        int          fl_cnt      = 0;
        logic [31:0] fl_hdr      = '0;
        longint      last_rise_t = 0;
        int          last_rises  = 0;
        logic [31:0] last_hdr    = '0;
        logic [31:0] model_hdr   = '0;

        initial io1[g] = 1'b0;

        always @(negedge csb[g]) begin
            fl_cnt = 0;
            fl_hdr = '0;
            io1[g] = 1'b0;
        end

        always @(posedge spiclk[g]) begin
            if (!csb[g]) begin
                if (fl_cnt > 0) check("sck_period", 32'($time - last_rise_t), 2 * D * PERIOD);
                last_rise_t = $time;
                if (fl_cnt < 32) fl_hdr = {fl_hdr[30:0], io0[g]};
                fl_cnt++;
            end
        end

        always @(negedge spiclk[g]) begin : serve
            int         k;
            logic [7:0] b;
            if (!csb[g] && fl_cnt >= 32 && fl_cnt < 64) begin
                k      = fl_cnt - 32;
                b      = mem_byte(fl_hdr[23:0] + 24'(k / 8));
                io1[g] = b[7 - (k % 8)];
            end
        end

        always @(posedge csb[g]) begin
            if (ap_rst === 1'b1) begin
                check("spi_rises", fl_cnt, 64);
                check("spi_header", fl_hdr, model_hdr);
            end
            last_rises = fl_cnt;
            last_hdr   = fl_hdr;
        end

        // Cycle model: timestamps of accept and response handshake decide every output.
        bit          in_fl       = 1'b0;
        int          t_acc       = 0;
        int          t_hs        = -100;
        int          csb_low_run = 0;
        int          last_low    = 0;
        logic [31:0] exp_q [$];
        logic [31:0] got_q [$];

        always @(negedge ap_clk) begin : cmp
            bit e_rr, e_csb, e_rv;
            if (!ap_rst) begin
                in_fl       = 1'b0;
                t_hs        = -100;
                csb_low_run = 0;
                exp_q.delete();
                check("rst_csb", csb[g], 1);
                check("rst_spiclk", spiclk[g], 0);
                check("rst_io0", io0[g], 0);
                check("rst_rsp_valid", rsp_valid[g], 0);
                check("rst_req_ready", req_ready[g], 1);
                check("rst_busy", busy[g], 0);
            end else begin
                e_rr  = !in_fl && (cyc > t_hs + CI);
                e_csb = !(in_fl && cyc >= t_acc + 1 && cyc <= t_acc + 130 * D);
                e_rv  = in_fl && (cyc >= t_acc + 1 + 130 * D);
                check("req_ready", req_ready[g], e_rr);
                check("busy", busy[g], !e_rr);
                check("csb", csb[g], e_csb);
                check("rsp_valid", rsp_valid[g], e_rv);
                if (csb[g]) check("spiclk_idle", spiclk[g], 0);
                if (e_rv && rsp_valid[g] && exp_q.size() > 0) check("rsp_data", rsp_data[g], exp_q[0]);
                if (!csb[g]) begin
                    csb_low_run++;
                end else if (csb_low_run > 0) begin
                    last_low    = csb_low_run;
                    csb_low_run = 0;
                end
                if (e_rv && rsp_ready[g]) begin
                    in_fl = 1'b0;
                    t_hs  = cyc;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    got_q.push_back(rsp_data[g]);
                end
                if (e_rr && req_valid[g]) begin
                    in_fl     = 1'b1;
                    t_acc     = cyc;
                    model_hdr = {8'h03, req_addr[g]};
                    exp_q.push_back(exp_word(req_addr[g]));
                end
            end
        end
    end

    // Raises req_valid just after a clock edge and returns the accept cycle.
    task automatic send(input int g, input logic [23:0] a, output int t);
        bit got;
        got = 1'b0;
        t   = -1;
        @(posedge ap_clk);
        #1;
        req_addr[g]  = a;
        req_valid[g] = 1'b1;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge ap_clk);
            if (req_ready[g]) begin
                got = 1'b1;
                t   = cyc;
            end
        end
        check("req_accepted", got, 1);
        @(posedge ap_clk);
        #1;
        req_valid[g] = 1'b0;
    endtask

    // Returns at the negedge of the first cycle with rsp_valid high.
    task automatic wait_rsp(input int g, output int t);
        bit got;
        got = 1'b0;
        t   = -1;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge ap_clk);
            if (rsp_valid[g]) begin
                got = 1'b1;
                t   = cyc;
            end
        end
        check("rsp_arrived", got, 1);
    endtask

    initial begin
        int ta, tb, tr, k;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_addr[i]  = '0;
            rsp_ready[i] = 1'b0;
        end

        repeat (3) @(negedge ap_clk);
        check("reset_csb", csb[0], 1);
        check("reset_spiclk", spiclk[0], 0);
        check("reset_io0", io0[0], 0);
        check("reset_req_ready", req_ready[0], 1);
        check("reset_rsp_valid", rsp_valid[0], 0);
        check("reset_rsp_data", rsp_data[0], 32'h0);
        check("reset_busy", busy[0], 0);
        check("reset_state", dbg_state[0], 0);
        #2 ap_rst = 1'b1;

        // Basic read, latency and chip-select width.
        @(posedge ap_clk);
        #1 rsp_ready[0] = 1'b1;
        send(0, 24'h000000, ta);
        wait_rsp(0, tr);
        check("basic_data", rsp_data[0], 32'h12345678);
        check("basic_latency", tr - ta, 261);
        repeat (8) @(negedge ap_clk);
        check("basic_csb_low", g_m[0].last_low, 260);

        // Wire pattern of the command/address header.
        send(0, 24'hA5C3F0, ta);
        wait_rsp(0, tr);
        repeat (8) @(negedge ap_clk);
        check("wire_header", g_m[0].last_hdr, 32'h03A5C3F0);
        check("wire_rises", g_m[0].last_rises, 64);
        check("wire_sck_idle", spiclk[0], 0);

        // Unaligned address.
        send(0, 24'h000001, ta);
        wait_rsp(0, tr);
        check("unaligned_data", rsp_data[0], 32'hAB123456);

        // Backpressure with a competing request held during the response.
        @(posedge ap_clk);
        #1 rsp_ready[0] = 1'b0;
        send(0, 24'h000004, ta);
        req_addr[0]  = 24'h000002;
        req_valid[0] = 1'b1;
        wait_rsp(0, tr);
        for (int i = 0; i < 50; i++) begin
            check("bp_valid", rsp_valid[0], 1);
            check("bp_data", rsp_data[0], 32'h01EFCDAB);
            check("bp_req_ready", req_ready[0], 0);
            @(negedge ap_clk);
        end
        @(posedge ap_clk);
        #1 rsp_ready[0] = 1'b1;
        @(negedge ap_clk);
        @(posedge ap_clk);
        #1 rsp_ready[0] = 1'b0;
        k = 0;
        for (int i = 0; i < 20 && !req_ready[0]; i++) begin
            @(negedge ap_clk);
            k++;
        end
        check("bp_gap_cycles", k, 5);
        @(posedge ap_clk);
        #1;
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        wait_rsp(0, tr);
        check("bp_pending_data", rsp_data[0], 32'hCDAB1234);
        repeat (8) @(negedge ap_clk);

        // Reset in the middle of the shift phase, with spiclk high.
        send(0, 24'h000000, ta);
        k = 0;
        for (int i = 0; i < 1000 && k == 0; i++) begin
            @(negedge ap_clk);
            if (g_m[0].fl_cnt >= 20 && spiclk[0]) k = 1;
        end
        check("rst_reached_bit20", k, 1);
        #2 ap_rst = 1'b0;
        #1;
        check("rst_async_csb", csb[0], 1);
        check("rst_async_spiclk", spiclk[0], 0);
        check("rst_async_rsp_valid", rsp_valid[0], 0);
        repeat (3) @(negedge ap_clk);
        #2 ap_rst = 1'b1;
        send(0, 24'h000000, ta);
        wait_rsp(0, tr);
        check("after_rst_data", rsp_data[0], 32'h12345678);
        check("after_rst_latency", tr - ta, 261);

        // Back-to-back on the CLK_DIV=1, CS_IDLE=0 instance.
        @(posedge ap_clk);
        #1 rsp_ready[1] = 1'b1;
        send(1, 24'h000000, ta);
        send(1, 24'h000004, tb);
        check("b2b_spacing", tb - ta, 132);
        wait_rsp(1, tr);
        check("b2b_latency", tr - tb, 131);
        repeat (6) @(negedge ap_clk);
        check("b2b_count", g_m[1].got_q.size(), 2);
        if (g_m[1].got_q.size() == 2) begin
            check("b2b_word0", g_m[1].got_q[0], 32'h12345678);
            check("b2b_word1", g_m[1].got_q[1], 32'h01EFCDAB);
        end

        repeat (10) @(negedge ap_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

    initial begin
        #(PERIOD * 20000);
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
